l2c_epc_ctl: RTL and testbench

//  Epoch controller for the L2C replacement logic. Owns the current epoch and min-CPU-ways config fed to the

---
 rtl/l2c_pkg.sv | 24 ++
 rtl/l2c_epc_timer.sv | 32 +++
 rtl/l2c_epc_ctl.sv | 163 ++++++++++++++++
 tb/tb_l2c_epc_ctl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/l2c_pkg.sv
// Shared L2C epoch-controller definitions: field widths, register map and FSM encoding.
// Pure declarations; no logic and no flow control.
package l2c_pkg;

  localparam int EPC_W    = 3;
  localparam int EPC_RD_W = 16;

  localparam logic [1:0] EPC_REG_CTRL    = 2'd0;
  localparam logic [1:0] EPC_REG_PERIOD  = 2'd1;
  localparam logic [1:0] EPC_REG_MINWAYS = 2'd2;
  localparam logic [1:0] EPC_REG_STAT    = 2'd3;

  typedef enum logic [1:0] {
    EPC_IDLE  = 2'd0,
    EPC_DRAIN = 2'd1,
    EPC_BUMP  = 2'd2
  } epc_state_t;

  // Zero-extends a register field onto the read-data bus.
  function automatic logic [EPC_RD_W-1:0] epc_rd_zext3(input logic [2:0] v);
    return {{(EPC_RD_W-3){1'b0}}, v};
  endfunction

endpackage

// File: rtl/l2c_epc_timer.sv
// Auto-advance period counter: combinational expiry on the last count of each period, frozen when asked.
// No handshake; clr restarts the count at 0 on the next cycle.
module l2c_epc_timer #(
  parameter int PERIOD_W = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic [PERIOD_W-1:0] period,
  input  logic                clr,
  input  logic                freeze,
  output logic                expire
);

  logic [PERIOD_W-1:0] cnt_q;
  logic                run;

  assign run    = !freeze && !clr && (period != '0);
  assign expire = run && (cnt_q == (period - PERIOD_W'(1)));

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (expire) begin
      cnt_q <= '0;
    end else if (run) begin
      cnt_q <= cnt_q + PERIOD_W'(1);
    end
  end

endmodule

// File: rtl/l2c_epc_ctl.sv
// Epoch controller for L2C replacement: advances epoch on timer/SW request once lookups drain.
// Epoch visible 3 cycles after an idle request; o_hold stalls new lookups from DRAIN entry until BUMP.
module l2c_epc_ctl
  import l2c_pkg::*;
#(
  parameter int PERIOD_W     = 16,
  parameter int MAX_PEND     = 8,
  parameter int MIN_WAYS_RST = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              i_lookup_start,
  input  logic              i_lookup_done,
  input  logic              i_reg_we,
  input  logic              i_reg_re,
  input  logic [1:0]        i_reg_addr,
  input  logic [15:0]       i_reg_wdata,
  output logic [15:0]       o_reg_rdata,
  output logic [EPC_W-1:0]  o_ctl_epoch,
  output logic [2:0]        o_ctl_min_cpu_ways,
  output logic              o_rnd_shift,
  output logic              o_hold,
  output logic              o_epoch_adv,
  output logic              o_err
);

  localparam int                PEND_W   = $clog2(MAX_PEND) + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PEND);

  epc_state_t          state_q, state_d;
  logic [EPC_W-1:0]    epoch_q;
  logic [2:0]          min_ways_q;
  logic [PERIOD_W-1:0] period_q;
  logic [PEND_W-1:0]   pend_q, pend_d;
  logic                pend_err;
  logic                adv_req_q;
  logic                hold_q;
  logic                epoch_adv_q;
  logic                rnd_shift_q;
  logic                err_q;
  logic [15:0]         rdata_q;

  logic wr_ctrl, wr_period, wr_minways, wr_stat;
  logic sw_adv, tmr_expire, adv_any, err_clr;

  assign wr_ctrl    = i_reg_we && (i_reg_addr == EPC_REG_CTRL);
  assign wr_period  = i_reg_we && (i_reg_addr == EPC_REG_PERIOD);
  assign wr_minways = i_reg_we && (i_reg_addr == EPC_REG_MINWAYS);
  assign wr_stat    = i_reg_we && (i_reg_addr == EPC_REG_STAT);

  assign sw_adv  = wr_ctrl && i_reg_wdata[0];
  assign err_clr = wr_stat && i_reg_wdata[15];
  // A fresh request leaves IDLE in the same cycle it arrives, so min latency stays at 3.
  assign adv_any = adv_req_q || sw_adv || tmr_expire;

  l2c_epc_timer #(
    .PERIOD_W (PERIOD_W)
  ) u_timer (
    .Clk    (Clk),
    .Reset  (Reset),
    .period (period_q),
    .clr    (wr_period),
    .freeze (state_q != EPC_IDLE),
    .expire (tmr_expire)
  );

  // Pending lookups: start and done in one cycle cancel; over/underflow saturates and flags.
  always_comb begin
    pend_d   = pend_q;
    pend_err = 1'b0;
    if (i_lookup_start && !i_lookup_done) begin
      if (pend_q == PEND_MAX) begin
        pend_err = 1'b1;
      end else begin
        pend_d = pend_q + PEND_W'(1);
      end
    end else if (!i_lookup_start && i_lookup_done) begin
      if (pend_q == '0) begin
        pend_err = 1'b1;
      end else begin
        pend_d = pend_q - PEND_W'(1);
      end
    end
    if (i_lookup_start && hold_q) begin
      pend_err = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EPC_IDLE:  if (adv_any) state_d = EPC_DRAIN;
      EPC_DRAIN: if (pend_d == '0) state_d = EPC_BUMP;
      EPC_BUMP:  state_d = EPC_IDLE;
      default:   state_d = EPC_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= EPC_IDLE;
      epoch_q     <= '0;
      pend_q      <= '0;
      adv_req_q   <= 1'b0;
      hold_q      <= 1'b0;
      epoch_adv_q <= 1'b0;
      rnd_shift_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      hold_q      <= (state_d != EPC_IDLE);
      epoch_adv_q <= (state_q == EPC_BUMP);
      rnd_shift_q <= i_lookup_start;
      if (state_q == EPC_BUMP) begin
        epoch_q <= epoch_q + EPC_W'(1);
      end
      // Requests landing during DRAIN/BUMP fold into the advance already in progress.
      if (state_q == EPC_BUMP) begin
        adv_req_q <= 1'b0;
      end else if (sw_adv || tmr_expire) begin
        adv_req_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      min_ways_q <= 3'(MIN_WAYS_RST);
      period_q   <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (wr_minways) begin
        min_ways_q <= i_reg_wdata[2:0];
      end
      if (wr_period) begin
        period_q <= i_reg_wdata[PERIOD_W-1:0];
      end
      if (pend_err) begin
        err_q <= 1'b1;
      end else if (err_clr) begin
        err_q <= 1'b0;
      end
      if (i_reg_re) begin
        case (i_reg_addr)
          EPC_REG_CTRL:    rdata_q <= epc_rd_zext3(epoch_q);
          EPC_REG_PERIOD:  rdata_q <= 16'(period_q);
          EPC_REG_MINWAYS: rdata_q <= epc_rd_zext3(min_ways_q);
          default:         rdata_q <= {err_q, 5'b0, 2'(state_q), 8'(pend_q)};
        endcase
      end
    end
  end

  assign o_reg_rdata        = rdata_q;
  assign o_ctl_epoch        = epoch_q;
  assign o_ctl_min_cpu_ways = min_ways_q;
  assign o_rnd_shift        = rnd_shift_q;
  assign o_hold             = hold_q;
  assign o_epoch_adv        = epoch_adv_q;
  assign o_err              = err_q;

endmodule

// File: tb/tb_l2c_epc_ctl.sv
// Directed bench for l2c_epc_ctl: hand-computed expectations checked 1 time unit after each rising edge.
module tb_l2c_epc_ctl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        i_lookup_start;
  logic        i_lookup_done;
  logic        i_reg_we;
  logic        i_reg_re;
  logic [1:0]  i_reg_addr;
  logic [15:0] i_reg_wdata;
  logic [15:0] o_reg_rdata;
  logic [2:0]  o_ctl_epoch;
  logic [2:0]  o_ctl_min_cpu_ways;
  logic        o_rnd_shift;
  logic        o_hold;
  logic        o_epoch_adv;
  logic        o_err;

  int vec_cnt = 0;
  int miscmp  = 0;

  always #5 Clk = ~Clk;

  l2c_epc_ctl dut (
    .Clk                (Clk),
    .Reset              (Reset),
    .i_lookup_start     (i_lookup_start),
    .i_lookup_done      (i_lookup_done),
    .i_reg_we           (i_reg_we),
    .i_reg_re           (i_reg_re),
    .i_reg_addr         (i_reg_addr),
    .i_reg_wdata        (i_reg_wdata),
    .o_reg_rdata        (o_reg_rdata),
    .o_ctl_epoch        (o_ctl_epoch),
    .o_ctl_min_cpu_ways (o_ctl_min_cpu_ways),
    .o_rnd_shift        (o_rnd_shift),
    .o_hold             (o_hold),
    .o_epoch_adv        (o_epoch_adv),
    .o_err              (o_err)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vec_cnt++;
    assert (obs === exp) else begin
      miscmp++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] addr, input logic [15:0] data);
    i_reg_we    = 1'b1;
    i_reg_addr  = addr;
    i_reg_wdata = data;
    tick();
    i_reg_we    = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [1:0] addr, input logic [15:0] exp);
    i_reg_re   = 1'b1;
    i_reg_addr = addr;
    tick();
    i_reg_re   = 1'b0;
    chk(tag, o_reg_rdata, exp);
  endtask

  initial begin
    Reset          = 1'b0;
    i_lookup_start = 1'b0;
    i_lookup_done  = 1'b0;
    i_reg_we       = 1'b0;
    i_reg_re       = 1'b0;
    i_reg_addr     = 2'd0;
    i_reg_wdata    = 16'h0;
    tick();
    tick();

    chk("rst_epoch", 16'(o_ctl_epoch), 16'd0);
    chk("rst_minways", 16'(o_ctl_min_cpu_ways), 16'd2);
    chk("rst_hold", 16'(o_hold), 16'd0);
    chk("rst_adv", 16'(o_epoch_adv), 16'd0);
    chk("rst_shift", 16'(o_rnd_shift), 16'd0);
    chk("rst_err", 16'(o_err), 16'd0);
    chk("rst_rdata", o_reg_rdata, 16'h0000);
    Reset = 1'b1;
    tick();

    // SW advance with nothing pending: hold for 2 cycles, new epoch on the 3rd.
    wr(2'd0, 16'h0001);
    chk("sw_hold1", 16'(o_hold), 16'd1);
    chk("sw_epoch1", 16'(o_ctl_epoch), 16'd0);
    tick();
    chk("sw_hold2", 16'(o_hold), 16'd1);
    chk("sw_adv2", 16'(o_epoch_adv), 16'd0);
    tick();
    chk("sw_hold3", 16'(o_hold), 16'd0);
    chk("sw_adv3", 16'(o_epoch_adv), 16'd1);
    chk("sw_epoch3", 16'(o_ctl_epoch), 16'd1);
    tick();
    chk("sw_adv4", 16'(o_epoch_adv), 16'd0);
    rd("rd_epoch", 2'd0, 16'h0001);

    wr(2'd2, 16'h0005);
    chk("minways_out", 16'(o_ctl_min_cpu_ways), 16'd5);
    rd("rd_minways", 2'd2, 16'h0005);

    i_lookup_start = 1'b1;
    tick();
    i_lookup_start = 1'b0;
    chk("shift_on", 16'(o_rnd_shift), 16'd1);
    rd("rd_pend1", 2'd3, 16'h0001);
    chk("shift_off", 16'(o_rnd_shift), 16'd0);
    i_lookup_done = 1'b1;
    tick();
    i_lookup_done = 1'b0;
    chk("pend_ok_err", 16'(o_err), 16'd0);

    // Underflow flags and saturates at 0, then SW clears.
    i_lookup_done = 1'b1;
    tick();
    i_lookup_done = 1'b0;
    chk("uflow_err", 16'(o_err), 16'd1);
    rd("rd_uflow", 2'd3, 16'h8000);
    wr(2'd3, 16'h8000);
    chk("uflow_clr", 16'(o_err), 16'd0);

    // Overflow on the 9th start, pending saturates at 8.
    for (int i = 0; i < 9; i++) begin
      i_lookup_start = 1'b1;
      tick();
      chk("oflow_err", 16'(o_err), (i == 8) ? 16'd1 : 16'd0);
    end
    i_lookup_start = 1'b0;
    rd("rd_oflow", 2'd3, 16'h8008);
    wr(2'd3, 16'h8000);
    chk("oflow_clr", 16'(o_err), 16'd0);
    i_lookup_done = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    i_lookup_done = 1'b0;
    rd("rd_drained", 2'd3, 16'h0000);

    wr(2'd1, 16'hA5A5);
    rd("rd_period", 2'd1, 16'hA5A5);
    wr(2'd1, 16'h0000);

    // Three lookups in flight; dones at +5, +8, +12 after the SW request.
    i_lookup_start = 1'b1;
    tick();
    tick();
    tick();
    i_lookup_start = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      chk("drn_hold", 16'(o_hold), (k >= 1 && k <= 13) ? 16'd1 : 16'd0);
      chk("drn_adv", 16'(o_epoch_adv), (k == 14) ? 16'd1 : 16'd0);
      chk("drn_epoch", 16'(o_ctl_epoch), (k >= 14) ? 16'd2 : 16'd1);
      i_reg_we      = (k == 0);
      i_reg_addr    = 2'd0;
      i_reg_wdata   = 16'h0001;
      i_lookup_done = (k == 5 || k == 8 || k == 12);
      tick();
    end
    i_reg_we      = 1'b0;
    i_lookup_done = 1'b0;
    chk("drn_err", 16'(o_err), 16'd0);

    // period=4: SW request collides with the first expiry, then a 6-cycle cadence through wrap.
    wr(2'd1, 16'd4);
    for (int k = 0; k <= 37; k++) begin
      chk("tmr_adv", 16'(o_epoch_adv), (k >= 6 && (k - 6) % 6 == 0) ? 16'd1 : 16'd0);
      chk("tmr_epoch", 16'(o_ctl_epoch), (k < 6) ? 16'd2 : 16'((3 + (k - 6) / 6) % 8));
      i_reg_we    = (k == 3);
      i_reg_addr  = 2'd0;
      i_reg_wdata = 16'h0001;
      tick();
    end
    i_reg_we = 1'b0;
    wr(2'd1, 16'd0);

    wr(2'd0, 16'h0001);
    tick();
    tick();
    tick();
    chk("pre_rst_epoch", 16'(o_ctl_epoch), 16'd1);

    // Reset asserted while draining two lookups.
    i_lookup_start = 1'b1;
    tick();
    tick();
    i_lookup_start = 1'b0;
    wr(2'd0, 16'h0001);
    tick();
    chk("mid_hold", 16'(o_hold), 16'd1);
    Reset = 1'b0;
    #2;
    chk("arst_epoch", 16'(o_ctl_epoch), 16'd0);
    chk("arst_hold", 16'(o_hold), 16'd0);
    chk("arst_minways", 16'(o_ctl_min_cpu_ways), 16'd2);
    chk("arst_rdata", o_reg_rdata, 16'h0000);
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    tick();
    rd("arst_stat", 2'd3, 16'h0000);
    rd("arst_rd_minways", 2'd2, 16'h0002);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
    $finish;
  end

endmodule
